// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences accesses from the EX load/store port and the IF fetch port onto one RAM.
// Optional macro MEM_ARB_RR_EN: round-robin between EX and IF on contention instead of fixed EX priority.
module mem_arbiter #(
    parameter int RD_LAT = 1,
    parameter int AW     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_req_i,
    input  logic          ex_we_i,
    input  logic [AW-1:0] ex_addr_i,
    input  logic [2:0]    ex_size_i,
    input  logic [31:0]   ex_wdata_i,
    output logic [31:0]   ex_rdata_o,
    output logic          ex_ack_o,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [31:0]   if_rdata_o,
    output logic          if_ack_o,
    output logic [AW-1:0] ram_addr_o,
    output logic          ram_rd_en_o,
    output logic          ram_wd_en_o,
    output logic [2:0]    ram_size_o,
    output logic [31:0]   ram_wdata_o,
    input  logic [31:0]   ram_rdata_i,
    output logic          hold_o
);

    // Handshake: a requester raises req with a stable command and holds it until its ack pulses
    // for one cycle; the command is captured at the grant edge, so req may fall early without aborting.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);

    state_t     state_q;
    logic [2:0] rd_cnt_q;
    logic       owner_if_q;
    logic       ex_size_ok;
    logic       grant_ex;
    logic       grant_if;

    assign ex_size_ok = (ex_size_i == 3'd1) || (ex_size_i == 3'd2) || (ex_size_i == 3'd4);

`ifdef MEM_ARB_RR_EN
    logic last_if_q;  // 1 when the most recent grant went to IF, so EX wins the next tie

    assign grant_ex = ex_req_i & (~if_req_i | last_if_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_if_q <= 1'b1;
        end else if (state_q == S_IDLE && (ex_req_i || if_req_i)) begin
            last_if_q <= ~grant_ex;
        end
    end
`else
    assign grant_ex = ex_req_i;
`endif

    assign grant_if = if_req_i & ~grant_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= 3'd0;
            owner_if_q  <= 1'b0;
            ex_ack_o    <= 1'b0;
            if_ack_o    <= 1'b0;
            ex_rdata_o  <= '0;
            if_rdata_o  <= '0;
            ram_addr_o  <= '0;
            ram_rd_en_o <= 1'b0;
            ram_wd_en_o <= 1'b0;
            ram_size_o  <= 3'd0;
            ram_wdata_o <= '0;
        end else begin
            ex_ack_o <= 1'b0;
            if_ack_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_ex) begin
                        ram_addr_o  <= ex_addr_i;
                        ram_size_o  <= ex_size_i;
                        ram_wdata_o <= ex_wdata_i;
                        owner_if_q  <= 1'b0;
                        rd_cnt_q    <= 3'd0;
                        if (!ex_size_ok) begin
                            // Unsupported size: answer immediately without touching the RAM.
                            ex_rdata_o <= '0;
                            ex_ack_o   <= 1'b1;
                            state_q    <= S_RESP;
                        end else if (ex_we_i) begin
                            ram_wd_en_o <= 1'b1;
                            state_q     <= S_WRITE;
                        end else begin
                            ram_rd_en_o <= 1'b1;
                            state_q     <= S_READ;
                        end
                    end else if (grant_if) begin
                        ram_addr_o  <= if_addr_i;
                        ram_size_o  <= 3'd4;
                        ram_wdata_o <= '0;
                        owner_if_q  <= 1'b1;
                        rd_cnt_q    <= 3'd0;
                        ram_rd_en_o <= 1'b1;
                        state_q     <= S_READ;
                    end
                end
                S_WRITE: begin
                    // Only EX can store, so the store response always goes to EX.
                    ram_wd_en_o <= 1'b0;
                    ex_rdata_o  <= '0;
                    ex_ack_o    <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_READ: begin
                    if (rd_cnt_q == RD_LAST) begin
                        ram_rd_en_o <= 1'b0;
                        if (owner_if_q) begin
                            if_rdata_o <= ram_rdata_i;
                            if_ack_o   <= 1'b1;
                        end else begin
                            ex_rdata_o <= ram_rdata_i;
                            ex_ack_o   <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 3'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hold_o = (ex_req_i & ~ex_ack_o) | (if_req_i & ~if_ack_o);

endmodule
